drink_selector: RTL and testbench

Parametrised successor of the coffee maker's drink-type decoder. It synchronises and debounces the one-hot drink switches and decodes them into a drink code. On a start request it locks that code and hands it to the brew controller through a valid/ready handshake. It then holds the selection frozen until the brew controller reports completion. It sits between the front-panel switch/button inputs and the brew sequencing FSM.

---
 rtl/drink_selector.sv | 162 ++++++++++++++++
 tb/tb_drink_selector.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/drink_selector.sv
// drink_selector: synchronises and debounces the one-hot drink switches,
// decodes them into a drink code, and offers that code to the brew
// controller through a valid/ready handshake. The selection stays frozen
// until the brew controller reports completion.
module drink_selector #(
  parameter int N_DRINKS        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  localparam int TYPE_W         = $clog2(N_DRINKS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_DRINKS-1:0] switches,
  input  logic                start,
  input  logic                cancel,
  input  logic                c_ready,
  input  logic                brew_done,
  output logic [TYPE_W-1:0]   c_type,
  output logic                c_valid,
  output logic                busy,
  output logic                sel_error,
  output logic                reject
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_BREW
  } state_t;

  logic [N_DRINKS-1:0] r_sync1;
  logic [N_DRINKS-1:0] r_sync2;
  logic [N_DRINKS-1:0] r_cand;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_stable;

  logic [TYPE_W-1:0]   w_code;
  logic                w_err;
  logic                w_hit;

  state_t              r_state;
  state_t              w_next;
  logic                w_refuse;

  logic [TYPE_W-1:0]   r_c_type;
  logic                r_c_valid;
  logic                r_busy;
  logic                r_sel_error;
  logic                r_reject;

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= switches;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: restart the window on any change, otherwise count up and saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (r_sync2 != r_cand) begin
      r_cand <= r_sync2;
      r_cnt  <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  assign w_stable = (r_sync2 == r_cand) && (r_cnt == CNT_MAX);

  // One-hot decode of the debounced pattern; multi-hot flags an error and yields code 0.
  always_comb begin
    w_code = '0;
    w_err  = 1'b0;
    w_hit  = 1'b0;
    for (int i = 0; i < N_DRINKS; i++) begin
      if (r_cand[i]) begin
        if (w_hit) begin
          w_err = 1'b1;
        end
        w_hit  = 1'b1;
        w_code = TYPE_W'(i + 1);
      end
    end
    if (w_err) begin
      w_code = '0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; start is judged against the registered selection, c_ready beats cancel.
  always_comb begin
    w_next   = r_state;
    w_refuse = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_stable && (r_c_type != '0) && !r_sel_error) begin
            w_next = S_REQ;
          end else begin
            w_refuse = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (c_ready) begin
          w_next = S_BREW;
        end else if (cancel) begin
          w_next = S_IDLE;
        end
      end
      S_BREW: begin
        if (brew_done) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Registered outputs; the selection only tracks the switches while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_type    <= '0;
      r_sel_error <= 1'b0;
      r_c_valid   <= 1'b0;
      r_busy      <= 1'b0;
      r_reject    <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_stable) begin
        r_c_type    <= w_code;
        r_sel_error <= w_err;
      end
      r_c_valid <= (w_next == S_REQ);
      r_busy    <= (w_next != S_IDLE);
      r_reject  <= w_refuse;
    end
  end

  assign c_type    = r_c_type;
  assign c_valid   = r_c_valid;
  assign busy      = r_busy;
  assign sel_error = r_sel_error;
  assign reject    = r_reject;

endmodule

// File: tb/tb_drink_selector.sv
// Bench for drink_selector: table-driven sequence on a 4-drink build with a
// scoreboard queue, plus hand-written async-reset and 7/1-drink build cases.
module tb_drink_selector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [3:0] sw4;
  logic       st4, cn4, rdy4, dn4;
  logic [2:0] ty4;
  logic       v4, b4, e4, r4;

  logic [6:0] sw7;
  logic       st7, cn7, rdy7, dn7;
  logic [2:0] ty7;
  logic       v7, b7, e7, r7;

  logic [0:0] sw1;
  logic       st1, cn1, rdy1, dn1;
  logic [0:0] ty1;
  logic       v1, b1, e1, r1;

  drink_selector #(.N_DRINKS(4), .DEBOUNCE_CYCLES(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .switches(sw4), .start(st4), .cancel(cn4),
    .c_ready(rdy4), .brew_done(dn4), .c_type(ty4), .c_valid(v4), .busy(b4),
    .sel_error(e4), .reject(r4)
  );

  drink_selector #(.N_DRINKS(7), .DEBOUNCE_CYCLES(4)) dut7 (
    .clk(clk), .rst_n(rst_n), .switches(sw7), .start(st7), .cancel(cn7),
    .c_ready(rdy7), .brew_done(dn7), .c_type(ty7), .c_valid(v7), .busy(b7),
    .sel_error(e7), .reject(r7)
  );

  drink_selector #(.N_DRINKS(1), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .switches(sw1), .start(st1), .cancel(cn1),
    .c_ready(rdy1), .brew_done(dn1), .c_type(ty1), .c_valid(v1), .busy(b1),
    .sel_error(e1), .reject(r1)
  );

  typedef struct {
    string      name;
    logic [2:0] ty;
    logic       v, b, e, r;
  } exp_t;

  typedef struct {
    logic [3:0] sw;
    logic       st, cn, rdy, dn;
    int         cyc;
    exp_t       ex;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(input string nm, input logic [3:0] sw,
                              input logic st, input logic cn, input logic rdy,
                              input logic dn, input int cyc, input logic [2:0] ty,
                              input logic v, input logic b, input logic e,
                              input logic r);
    vec_t t;
    t.sw = sw; t.st = st; t.cn = cn; t.rdy = rdy; t.dn = dn; t.cyc = cyc;
    t.ex.name = nm; t.ex.ty = ty; t.ex.v = v; t.ex.b = b; t.ex.e = e; t.ex.r = r;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic chk4(input string nm, input logic [2:0] ty, input logic v,
                      input logic b, input logic e, input logic r);
    chk({nm, ".c_type"},    {5'b0, ty4}, {5'b0, ty});
    chk({nm, ".c_valid"},   {7'b0, v4},  {7'b0, v});
    chk({nm, ".busy"},      {7'b0, b4},  {7'b0, b});
    chk({nm, ".sel_error"}, {7'b0, e4},  {7'b0, e});
    chk({nm, ".reject"},    {7'b0, r4},  {7'b0, r});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t ex;
    //             name             sw       st cn rd dn cyc ty v  b  e  r
    tbl.push_back(mk("pre_latency",  4'b0100, 0, 0, 0, 0, 18, 0, 0, 0, 0, 0));
    tbl.push_back(mk("latency_c3",   4'b0100, 0, 0, 0, 0, 1,  3, 0, 0, 0, 0));
    tbl.push_back(mk("sw1_wait",     4'b0001, 0, 0, 0, 0, 18, 3, 0, 0, 0, 0));
    tbl.push_back(mk("sw1_ready",    4'b0001, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0));
    tbl.push_back(mk("glitch",       4'b0011, 0, 0, 0, 0, 5,  1, 0, 0, 0, 0));
    tbl.push_back(mk("glitch_gone",  4'b0001, 0, 0, 0, 0, 20, 1, 0, 0, 0, 0));
    tbl.push_back(mk("multi_wait",   4'b0011, 0, 0, 0, 0, 18, 1, 0, 0, 0, 0));
    tbl.push_back(mk("multi_err",    4'b0011, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0));
    tbl.push_back(mk("start_reject", 4'b0011, 1, 0, 0, 0, 1,  0, 0, 0, 1, 1));
    tbl.push_back(mk("reject_one",   4'b0011, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0));
    tbl.push_back(mk("sw2_wait",     4'b0010, 0, 0, 0, 0, 18, 0, 0, 0, 1, 0));
    tbl.push_back(mk("sw2_ready",    4'b0010, 0, 0, 0, 0, 1,  2, 0, 0, 0, 0));
    tbl.push_back(mk("start_ok",     4'b0010, 1, 0, 0, 0, 1,  2, 1, 1, 0, 0));
    tbl.push_back(mk("req_frozen",   4'b1000, 0, 0, 0, 0, 20, 2, 1, 1, 0, 0));
    tbl.push_back(mk("req_start_ign",4'b1000, 1, 0, 0, 0, 1,  2, 1, 1, 0, 0));
    tbl.push_back(mk("ready_brew",   4'b1000, 0, 0, 1, 0, 1,  2, 0, 1, 0, 0));
    tbl.push_back(mk("brew_ign",     4'b1000, 1, 1, 0, 0, 1,  2, 0, 1, 0, 0));
    tbl.push_back(mk("brew_hold",    4'b1000, 0, 0, 0, 0, 3,  2, 0, 1, 0, 0));
    tbl.push_back(mk("brew_done",    4'b1000, 0, 0, 0, 1, 1,  2, 0, 0, 0, 0));
    tbl.push_back(mk("type_resume",  4'b1000, 0, 0, 0, 0, 1,  4, 0, 0, 0, 0));
    tbl.push_back(mk("idle_ign",     4'b1000, 0, 0, 1, 1, 1,  4, 0, 0, 0, 0));
    tbl.push_back(mk("start2",       4'b1000, 1, 0, 0, 0, 1,  4, 1, 1, 0, 0));
    tbl.push_back(mk("rdy_wins",     4'b1000, 0, 1, 1, 0, 1,  4, 0, 1, 0, 0));
    tbl.push_back(mk("done2",        4'b1000, 0, 0, 0, 1, 1,  4, 0, 0, 0, 0));
    tbl.push_back(mk("start3",       4'b1000, 1, 0, 0, 0, 1,  4, 1, 1, 0, 0));
    tbl.push_back(mk("cancel",       4'b1000, 0, 1, 0, 0, 1,  4, 0, 0, 0, 0));
    tbl.push_back(mk("start4",       4'b1000, 1, 0, 0, 0, 1,  4, 1, 1, 0, 0));
    tbl.push_back(mk("brew_for_rst", 4'b1000, 0, 0, 1, 0, 1,  4, 0, 1, 0, 0));

    rst_n = 1'b0;
    sw4 = '0; st4 = 0; cn4 = 0; rdy4 = 0; dn4 = 0;
    sw7 = '0; st7 = 0; cn7 = 0; rdy7 = 0; dn7 = 0;
    sw1 = '0; st1 = 0; cn1 = 0; rdy1 = 0; dn1 = 0;
    step();
    step();
    chk4("reset", 3'd0, 0, 0, 0, 0);
    chk("reset7.c_type", {5'b0, ty7}, 8'd0);
    chk("reset1.c_type", {7'b0, ty1}, 8'd0);

    // Release reset with the first pattern already on the switches.
    rst_n = 1'b1;
    sw4 = 4'b0100;

    for (int i = 0; i < tbl.size(); i++) begin
      sw4 = tbl[i].sw; st4 = tbl[i].st; cn4 = tbl[i].cn;
      rdy4 = tbl[i].rdy; dn4 = tbl[i].dn;
      sb.push_back(tbl[i].ex);
      step();
      st4 = 0; cn4 = 0; rdy4 = 0; dn4 = 0;
      repeat (tbl[i].cyc - 1) step();
      ex = sb.pop_front();
      chk4(ex.name, ex.ty, ex.v, ex.b, ex.e, ex.r);
    end

    // Asynchronous reset mid-BREW, well away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk4("async_rst", 3'd0, 0, 0, 0, 0);
    sw4 = 4'b0000;
    step();
    step();
    chk4("rst_held", 3'd0, 0, 0, 0, 0);
    rst_n = 1'b1;
    st4 = 1'b1;
    step();
    st4 = 1'b0;
    chk4("post_rst_reject", 3'd0, 0, 0, 0, 1);
    step();
    chk4("post_rst_clear", 3'd0, 0, 0, 0, 0);

    // Wider and single-drink builds share the clock and see the same edges.
    sw7 = 7'b1000000;
    sw1 = 1'b1;
    repeat (3) step();
    chk("n1_before.c_type", {7'b0, ty1}, 8'd0);
    step();
    chk("n1_after.c_type", {7'b0, ty1}, 8'd1);
    chk("n1_after.sel_error", {7'b0, e1}, 8'd0);
    step();
    step();
    chk("n7_before.c_type", {5'b0, ty7}, 8'd0);
    step();
    chk("n7_after.c_type", {5'b0, ty7}, 8'd7);
    chk("n7_after.sel_error", {7'b0, e7}, 8'd0);
    st7 = 1'b1;
    st1 = 1'b1;
    step();
    st7 = 1'b0;
    st1 = 1'b0;
    chk("n7_start.c_valid", {7'b0, v7}, 8'd1);
    chk("n7_start.busy", {7'b0, b7}, 8'd1);
    chk("n1_start.c_valid", {7'b0, v1}, 8'd1);
    chk("n7_start.reject", {7'b0, r7}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
